csr_mfile: RTL and testbench
============================

Name: csr_mfile

Overview:
Machine-mode CSR register file; the responder that executes CSR access requests from the execute stage (CSRRW/CSRRS/CSRRC).
Holds machine status/trap state and the 64-bit cycle and instret counters.
Applies trap entry and MRET side effects.
Exports the trap vector, mepc and an interrupt-pending flag to the fetch/commit logic.

Parameters:
HART_ID, 32'h0, value returned by mhartid
VENDOR_ID, 32'h0, value returned by mvendorid
ARCH_ID, 32'h0, value returned by marchid
IMP_ID, 32'h0, value returned by mimpid
MISA_EXT, 26'h0001100, misa extensions field (I, M); mxl reads 2'b01

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CSR request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  2  01 RW, 10 RS, 11 RC, 00 reserved (treated as illegal)
req_addr  in  12  CSR address
req_wdata  in  32  rs1/uimm operand
req_no_write  in  1  rs1/uimm is zero for RS/RC: read only, no write side effect
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  32  old CSR value
rsp_illegal  out  1  illegal-instruction indication
trap_valid  in  1  trap entry this cycle
trap_cause  in  32  mcause value (bit31 = interrupt)
trap_pc  in  32  faulting pc
trap_tval  in  32  mtval value
mret_valid  in  1  MRET commits this cycle
retire  in  1  one instruction retired
irq_ext, irq_timer, irq_sw  in  1 each  level interrupt lines
trap_vector  out  32  handler address for the current trap_cause
mepc_o  out  32  current mepc
irq_pending  out  1  mstatus.mie & |(mip & mie)

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_illegal=0; mstatus.mie=mpie=0; mtvec=0, mepc=0, mcause=0, mtval=0, mscratch=0, mie=0; counters=0.
- Handshake: one-entry response buffer; req_ready = !rsp_valid | rsp_ready.
  - An accepted request produces rsp_valid on the next cycle.
  - rsp_rdata and rsp_illegal are held stable until rsp_ready.
- Read/write: rdata is the pre-write value. The write takes effect at the accept edge.
  - RW writes wdata. RS writes old|wdata. RC writes old&~wdata.
  - With req_no_write, RS/RC perform no write.
- Illegal, when any of:
  - the address is unimplemented;
  - req_op=00;
  - addr[11:10]==2'b11 with a write (RW always writes).
  - An illegal request returns rdata=0 and has no side effect.
- Address map:
  - 300 mstatus, 301 misa, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 343 mtval, 344 mip.
  - B00/B80 mcycle/h, B02/B82 minstret/h.
  - F11-F14 vendor/arch/imp/hart id.
- WARL fields:
  - mstatus: only mie(3) and mpie(7) are writable; mpp reads 2'b11; all other bits read 0.
  - misa writes are ignored.
  - mie: only bits 11, 7, 3 are writable.
  - mip reads {irq_ext@11, irq_timer@7, irq_sw@3}; writes are ignored.
  - mepc bits[1:0] are forced to 0.
  - mtvec.mode accepts only 0 or 1; a write of 2 or 3 keeps the old mode while base updates.
- trap_vector: base<<2 when mode=0, or when trap_cause[31]=0. Otherwise base<<2 + 4*trap_cause[4:0], modulo 2^32.
- Trap entry (trap_valid): mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, mpie<=mie, mie<=0.
- MRET: mie<=mpie, mpie<=1.
- Priority in one cycle: trap_valid > mret_valid > CSR write.
  - A request accepted alongside trap_valid still responds with the old value, but its write is discarded.
  - trap_valid and mret_valid together: the trap wins and MRET is ignored.
- Counters:
  - mcycle increments every cycle; minstret increments when retire=1.
  - Each is 64-bit, with the carry from the low to the high half in the same cycle. All-ones wraps to 0.
  - A CSR write to either half in a cycle suppresses that counter's increment in that cycle; the written value lands exactly.
  - Reads return the value before that cycle's increment.
- Mid-operation reset: a pending response is dropped; rsp_valid goes to 0 immediately (asynchronously).

Decomposition:
- Shared package (alongside the existing CSR typedefs):
  - CSR address constants;
  - the csr_op_t enum (RW/RS/RC);
  - WARL write-mask constants for mstatus and mie;
  - a mcause interrupt-bit constant.
- Reuse the existing mstatus_t, mtvec_t and misa_t packed structs for storage.
- One sub-module, csr_counter64: 64-bit counter with an increment enable, lo/hi write ports and write-over-increment priority. Instantiated twice (mcycle, minstret).

Test Plan:
- RW 305 wdata=32'h8000_0101, then RS 305 wdata=0 with no_write -> second rdata=32'h8000_0101; a subsequent RW of 32'h8000_0103 reads back 32'h8000_0101 (mode kept at 1).
- mtvec=32'h8000_0101, trap_cause=32'h8000_0007 -> trap_vector=32'h8000_011C; cause=2 -> 32'h8000_0100.
- mstatus.mie=1, trap_valid with pc=32'h0000_1236 -> mepc=32'h0000_1234, mstatus=32'h0000_1880; MRET -> mstatus=32'h0000_1888.
- RW F14 -> rsp_illegal=1, rdata=0; RS F14 with no_write -> rdata=HART_ID, illegal=0; RW 7C0 -> illegal=1.
- Write mcycle lo=32'hFFFF_FFFF, hi=0 (consecutive RW) -> two cycles later mcycleh reads 1; a write to B00 in a cycle shows the exact written value the next cycle.
- Hold rsp_ready=0 for 3 cycles -> req_ready=0, rsp_rdata stable; assert rst_n=0 mid-hold -> rsp_valid=0 immediately.

Source files
------------

// File: rtl/csr_mfile_pkg.sv
// Shared machine-mode CSR definitions: addresses, access ops, WARL masks and storage structs.
package csr_mfile_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_ILL = 2'b00,
    CSR_OP_RW  = 2'b01,
    CSR_OP_RS  = 2'b10,
    CSR_OP_RC  = 2'b11
  } csr_op_t;

  // Writable bits: mstatus.mpie(7)/mie(3); mie.meie(11)/mtie(7)/msie(3).
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

  localparam int unsigned MCAUSE_INT_BIT = 31;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  typedef struct packed {
    logic [1:0]  mxl;
    logic [3:0]  zero;
    logic [25:0] ext;
  } misa_t;

endpackage

// File: rtl/csr_mfile_counter64.sv
// 64-bit free-running counter with 32-bit half write ports; a write in a cycle wins over the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  // Next count: written halves land exactly, otherwise a full-width increment (carry into hi same cycle).
  always_comb begin
    count_d = count_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) count_d[31:0]  = wdata;
      if (wr_hi) count_d[63:32] = wdata;
    end else if (inc_en) begin
      count_d = count_q + 64'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_mfile.sv
// Machine-mode CSR file: executes CSRRW/RS/RC requests with a one-entry response buffer,
// holds trap state and the cycle/instret counters, and applies trap entry and MRET.
module csr_mfile
  import csr_mfile_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] VENDOR_ID = 32'h0,
  parameter logic [31:0] ARCH_ID   = 32'h0,
  parameter logic [31:0] IMP_ID    = 32'h0,
  parameter logic [25:0] MISA_EXT  = 26'h0001100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_no_write,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic        retire,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_sw,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_o,
  output logic        irq_pending
);

  localparam misa_t MISA_VAL = misa_t'({2'b01, 4'b0000, MISA_EXT});

  mstatus_t    mstatus_q, mstatus_d;
  mtvec_t      mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mie_q, mie_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [63:0] mcycle, minstret;
  logic [31:0] mip, mstatus_rd, csr_old, csr_new, tvec_base;
  logic        csr_hit, csr_wr, illegal, accept, do_write;
  csr_op_t     op;

  assign op         = csr_op_t'(req_op);
  assign req_ready  = !rsp_valid_q || rsp_ready;
  assign accept     = req_valid && req_ready;
  assign mip        = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_q.mpie, 3'b0, mstatus_q.mie, 3'b0};

  // Read decode: old value of the addressed CSR (counters read before this cycle's increment).
  always_comb begin
    csr_hit = 1'b1;
    csr_old = '0;
    case (req_addr)
      CSR_MSTATUS:   csr_old = mstatus_rd;
      CSR_MISA:      csr_old = MISA_VAL;
      CSR_MIE:       csr_old = mie_q;
      CSR_MTVEC:     csr_old = mtvec_q;
      CSR_MSCRATCH:  csr_old = mscratch_q;
      CSR_MEPC:      csr_old = mepc_q;
      CSR_MCAUSE:    csr_old = mcause_q;
      CSR_MTVAL:     csr_old = mtval_q;
      CSR_MIP:       csr_old = mip;
      CSR_MCYCLE:    csr_old = mcycle[31:0];
      CSR_MCYCLEH:   csr_old = mcycle[63:32];
      CSR_MINSTRET:  csr_old = minstret[31:0];
      CSR_MINSTRETH: csr_old = minstret[63:32];
      CSR_MVENDORID: csr_old = VENDOR_ID;
      CSR_MARCHID:   csr_old = ARCH_ID;
      CSR_MIMPID:    csr_old = IMP_ID;
      CSR_MHARTID:   csr_old = HART_ID;
      default:       csr_hit = 1'b0;
    endcase
  end

  // Op decode: write intent, legality and the read-modify-write result.
  always_comb begin
    csr_wr  = (op == CSR_OP_RW) || ((op == CSR_OP_RS || op == CSR_OP_RC) && !req_no_write);
    illegal = !csr_hit || (op == CSR_OP_ILL) || ((req_addr[11:10] == 2'b11) && csr_wr);
    case (op)
      CSR_OP_RW: csr_new = req_wdata;
      CSR_OP_RS: csr_new = csr_old | req_wdata;
      CSR_OP_RC: csr_new = csr_old & ~req_wdata;
      default:   csr_new = csr_old;
    endcase
  end

  // A trap in the same cycle discards the request's write; the response still carries the old value.
  assign do_write = accept && !illegal && csr_wr && !trap_valid;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (1'b1),
    .wr_lo   (do_write && (req_addr == CSR_MCYCLE)),
    .wr_hi   (do_write && (req_addr == CSR_MCYCLEH)),
    .wdata   (csr_new),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (retire),
    .wr_lo   (do_write && (req_addr == CSR_MINSTRET)),
    .wr_hi   (do_write && (req_addr == CSR_MINSTRETH)),
    .wdata   (csr_new),
    .count_o (minstret)
  );

  // Architectural state update: trap entry over MRET over CSR write.
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mscratch_d = mscratch_q;
    mie_d      = mie_q;
    if (trap_valid) begin
      mepc_d         = {trap_pc[31:2], 2'b00};
      mcause_d       = trap_cause;
      mtval_d        = trap_tval;
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie  = 1'b0;
    end else begin
      if (mret_valid) begin
        mstatus_d.mie  = mstatus_q.mpie;
        mstatus_d.mpie = 1'b1;
      end else if (do_write && (req_addr == CSR_MSTATUS)) begin
        mstatus_d.mie  = csr_new[3] & MSTATUS_WMASK[3];
        mstatus_d.mpie = csr_new[7] & MSTATUS_WMASK[7];
      end
      if (do_write) begin
        case (req_addr)
          CSR_MIE:      mie_d = csr_new & MIE_WMASK;
          CSR_MTVEC: begin
            mtvec_d.base = csr_new[31:2];
            // Only direct (0) and vectored (1) modes exist; other encodings leave mode alone.
            if (!csr_new[1]) mtvec_d.mode = csr_new[1:0];
          end
          CSR_MSCRATCH: mscratch_d = csr_new;
          CSR_MEPC:     mepc_d     = {csr_new[31:2], 2'b00};
          CSR_MCAUSE:   mcause_d   = csr_new;
          CSR_MTVAL:    mtval_d    = csr_new;
          default: ;
        endcase
      end
    end
  end

  // Response buffer: load on accept, hold until consumed.
  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_illegal_d = rsp_illegal_q;
    if (accept) begin
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = illegal ? 32'h0 : csr_old;
      rsp_illegal_d = illegal;
    end else if (rsp_ready) begin
      rsp_valid_d   = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q     <= '0;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mscratch_q    <= '0;
      mie_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      mstatus_q     <= mstatus_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mscratch_q    <= mscratch_d;
      mie_q         <= mie_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign tvec_base   = {mtvec_q.base, 2'b00};
  assign trap_vector = ((mtvec_q.mode == 2'b01) && trap_cause[MCAUSE_INT_BIT])
                       ? tvec_base + {25'b0, trap_cause[4:0], 2'b00}
                       : tvec_base;
  assign mepc_o      = mepc_q;
  assign irq_pending = mstatus_q.mie && |(mip & mie_q);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_csr_mfile.sv
// Scoreboard bench for csr_mfile: a behavioural model predicts each accepted request's response
// and the per-cycle outputs; a monitor compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_csr_mfile;

  localparam logic [31:0] P_HART   = 32'h0000_0005;
  localparam logic [31:0] P_VENDOR = 32'h1234_0000;
  localparam logic [31:0] P_ARCH   = 32'h0000_0007;
  localparam logic [31:0] P_IMP    = 32'h0000_0009;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_no_write;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic        trap_valid, mret_valid, retire;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        irq_ext, irq_timer, irq_sw;
  logic [31:0] trap_vector, mepc_o;
  logic        irq_pending;

  csr_mfile #(
    .HART_ID(P_HART), .VENDOR_ID(P_VENDOR), .ARCH_ID(P_ARCH), .IMP_ID(P_IMP), .MISA_EXT(26'h0001100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_no_write(req_no_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .retire(retire),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .trap_vector(trap_vector), .mepc_o(mepc_o), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ill;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  // Reference model state.
  logic        m_mie, m_mpie, m_busy;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_mie_r;
  logic [63:0] m_cyc, m_ins;
  logic        exp_req_ready, exp_rsp_valid, exp_irq;
  logic [31:0] exp_tv, exp_mepc;

  logic [11:0] addr_tab [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11,
                                 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h123, 12'h306};

  function automatic void chk32(string n, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, want, $time);
    end
  endfunction

  function automatic void chk1(string n, logic act, logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", n, act, want, $time);
    end
  endfunction

  function automatic logic [31:0] m_mip();
    return (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_sw ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] m_tvec();
    logic [31:0] b;
    b = {m_mtvec[31:2], 2'b00};
    if (m_mtvec[1:0] == 2'd1 && trap_cause[31]) return b + 32'(trap_cause[4:0]) * 32'd4;
    return b;
  endfunction

  function automatic void m_read(input logic [11:0] a, output logic hit, output logic [31:0] v);
    hit = 1'b1;
    v   = 32'h0;
    case (a)
      12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h301: v = 32'h4000_0000 + 32'h0000_1100;
      12'h304: v = m_mie_r;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip();
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hF11: v = P_VENDOR;
      12'hF12: v = P_ARCH;
      12'hF13: v = P_IMP;
      12'hF14: v = P_HART;
      default: hit = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_busy = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0; m_mie_r = 0;
    m_cyc = 0; m_ins = 0;
    sb.delete();
  endtask

  // Predict outputs visible now, then advance the model across the coming rising edge.
  task automatic model_step();
    logic        acc, hit, ill, wr, cyc_w, ins_w;
    logic [31:0] old, nv;
    rsp_t        e;
    exp_req_ready = !m_busy || rsp_ready;
    exp_rsp_valid = m_busy;
    exp_tv        = m_tvec();
    exp_mepc      = m_mepc;
    exp_irq       = m_mie && ((m_mip() & m_mie_r) != 0);
    acc = req_valid && exp_req_ready;
    wr  = 0;
    nv  = 0;
    if (acc) begin
      m_read(req_addr, hit, old);
      wr  = (req_op == 2'b01) || (req_op != 2'b00 && !req_no_write);
      ill = !hit || req_op == 2'b00 || (req_addr[11:10] == 2'b11 && wr);
      e.rdata = ill ? 32'h0 : old;
      e.ill   = ill;
      sb.push_back(e);
      if (ill) wr = 0;
      case (req_op)
        2'b01:   nv = req_wdata;
        2'b10:   nv = old | req_wdata;
        default: nv = old & ~req_wdata;
      endcase
    end
    if (acc) m_busy = 1;
    else if (rsp_ready) m_busy = 0;
    if (trap_valid) wr = 0;
    cyc_w = wr && (req_addr == 12'hB00 || req_addr == 12'hB80);
    ins_w = wr && (req_addr == 12'hB02 || req_addr == 12'hB82);
    if (trap_valid) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
      m_mpie = m_mie; m_mie = 0;
    end else if (mret_valid) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (wr && req_addr == 12'h300) begin
      m_mie = nv[3]; m_mpie = nv[7];
    end
    if (wr) begin
      case (req_addr)
        12'h304: m_mie_r = nv & 32'h888;
        12'h305: m_mtvec = {nv[31:2], (nv[1:0] <= 2'd1) ? nv[1:0] : m_mtvec[1:0]};
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: m_cyc[31:0] = nv;
        12'hB80: m_cyc[63:32] = nv;
        12'hB02: m_ins[31:0] = nv;
        12'hB82: m_ins[63:32] = nv;
        default: ;
      endcase
    end
    if (!cyc_w) m_cyc = m_cyc + 64'd1;
    if (!ins_w && retire) m_ins = m_ins + 64'd1;
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_op = 2'b00; req_addr = 12'h0; req_wdata = 0; req_no_write = 0;
    rsp_ready = 1; trap_valid = 0; mret_valid = 0; retire = 0;
    trap_cause = 0; trap_pc = 0; trap_tval = 0;
    irq_ext = 0; irq_timer = 0; irq_sw = 0;
  endtask

  task automatic req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic nw);
    req_valid = 1; req_op = op; req_addr = a; req_wdata = wd; req_no_write = nw;
    cyc();
    req_valid = 0;
  endtask

  // Monitor: compares presented outputs against the model's predictions and the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        chk1("req_ready", req_ready, exp_req_ready);
        chk1("rsp_valid", rsp_valid, exp_rsp_valid);
        chk32("trap_vector", trap_vector, exp_tv);
        chk32("mepc_o", mepc_o, exp_mepc);
        chk1("irq_pending", irq_pending, exp_irq);
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected: got rdata %h with no expected entry", rsp_rdata);
          end else begin
            chk32("rsp_rdata", rsp_rdata, sb[0].rdata);
            chk1("rsp_illegal", rsp_illegal, sb[0].ill);
            if (rsp_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_illegal", rsp_illegal, 1'b0);
    chk32("rst_mepc", mepc_o, 32'h0);
    chk32("rst_trap_vector", trap_vector, 32'h0);
    chk1("rst_irq_pending", irq_pending, 1'b0);
    rst_n = 1;
    chk_en = 1;

    // mtvec WARL mode and vectored trap_vector.
    req(2'b01, 12'h305, 32'h8000_0101, 0);
    req(2'b10, 12'h305, 32'h0, 1);
    req(2'b01, 12'h305, 32'h8000_0103, 0);
    req(2'b10, 12'h305, 32'h0, 1);
    trap_cause = 32'h8000_0007;
    cyc();
    chk32("tvec_irq7", trap_vector, 32'h8000_011C);
    trap_cause = 32'h0000_0002;
    cyc();
    chk32("tvec_exc2", trap_vector, 32'h8000_0100);

    // Trap entry and MRET on mstatus.
    req(2'b01, 12'h300, 32'h0000_0008, 0);
    trap_valid = 1; trap_pc = 32'h0000_1236; trap_tval = 32'h0000_0ABC;
    req(2'b01, 12'h340, 32'hDEAD_BEEF, 0);
    trap_valid = 0;
    cyc();
    chk32("trap_mepc", mepc_o, 32'h0000_1234);
    req(2'b10, 12'h300, 32'h0, 1);
    req(2'b10, 12'h340, 32'h0, 1);
    mret_valid = 1;
    cyc();
    mret_valid = 0;
    req(2'b10, 12'h300, 32'h0, 1);
    req(2'b01, 12'h304, 32'hFFFF_FFFF, 0);
    irq_timer = 1;
    cyc();
    chk1("irq_timer_pending", irq_pending, 1'b1);
    req(2'b10, 12'h344, 32'hFFFF_FFFF, 1);
    irq_timer = 0;

    // Legality.
    req(2'b01, 12'hF14, 32'h1, 0);
    req(2'b10, 12'hF14, 32'h0, 1);
    req(2'b01, 12'h7C0, 32'h1, 0);
    req(2'b00, 12'h300, 32'h0, 0);
    req(2'b11, 12'hF11, 32'h0, 1);

    // Counter carry and write-over-increment.
    req(2'b01, 12'hB00, 32'hFFFF_FFFF, 0);
    req(2'b01, 12'hB80, 32'h0, 0);
    req(2'b10, 12'hB80, 32'h0, 1);
    req(2'b10, 12'hB80, 32'h0, 1);
    req(2'b01, 12'hB00, 32'h1234_5678, 0);
    req(2'b10, 12'hB00, 32'h0, 1);
    retire = 1;
    req(2'b01, 12'hB02, 32'hFFFF_FFFE, 0);
    req(2'b10, 12'hB02, 32'h0, 1);
    req(2'b10, 12'hB82, 32'h0, 1);
    req(2'b10, 12'hB82, 32'h0, 1);
    retire = 0;
    cyc();

    // Back-pressure hold, then reset while a response is pending.
    rsp_ready = 0;
    req(2'b10, 12'h341, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      req(2'b01, 12'h340, $urandom, 0);
      chk1("hold_req_ready", req_ready, 1'b0);
    end
    chk_en = 0;
    #2;
    chk1("pend_before_rst", rsp_valid, 1'b1);
    rst_n = 0;
    #1;
    chk1("async_rst_rsp_valid", rsp_valid, 1'b0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      req_valid    = ($urandom_range(0, 3) != 0);
      req_op       = 2'($urandom_range(0, 3));
      req_addr     = addr_tab[$urandom_range(0, 19)];
      req_wdata    = $urandom;
      req_no_write = ($urandom_range(0, 3) == 0);
      rsp_ready    = ($urandom_range(0, 9) < 7);
      trap_valid   = ($urandom_range(0, 15) == 0);
      mret_valid   = ($urandom_range(0, 15) == 0);
      retire       = $urandom_range(0, 1) == 1;
      trap_cause   = $urandom;
      trap_pc      = $urandom;
      trap_tval    = $urandom;
      irq_ext      = $urandom_range(0, 1) == 1;
      irq_timer    = $urandom_range(0, 1) == 1;
      irq_sw       = $urandom_range(0, 1) == 1;
      cyc();
    end

    idle_inputs();
    repeat (4) cyc();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d responses outstanding want 0", sb.size());
    end
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
